// File: rtl/cirno9_pkg.sv
// -----------------------------------------------------------------------------
// cirno9_pkg
//   Shared definitions for the cirno9 load/store responder: bus and lane
//   widths, wait-counter width, FSM state encoding and the address-window
//   check used at request accept time.
// -----------------------------------------------------------------------------
package cirno9_pkg;

   localparam int DW    = 32;   // data word width
   localparam int NLANE = 4;    // byte lanes per word
   localparam int CW    = 4;    // wait-state counter width (0..15)

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACC  = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // Window test in 33-bit arithmetic so a window ending at 4 GiB does not
   // wrap back to address 0.
   function automatic logic in_window(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input logic [32:0] win_end);
      logic [32:0] a33;
      a33 = {1'b0, adr};
      return (a33 >= {1'b0, base}) && (a33 < win_end);
   endfunction

endpackage

// File: rtl/cirno9_sram_bank.sv
// -----------------------------------------------------------------------------
// cirno9_sram_bank
//   DEPTH x 32 single-port synchronous SRAM with per-byte write enables.
//   A read (en=1, we=0) returns the addressed word on dout one cycle later;
//   dout holds its value until the next read. Contents are not reset.
// Ports
//   clk   in   1      clock
//   en    in   1      bank enable for this cycle
//   we    in   4      byte-lane write enables (all zero = read)
//   adr   in   AW     word index
//   din   in   32     write data
//   dout  out  32     read data (registered)
// -----------------------------------------------------------------------------
module cirno9_sram_bank
   import cirno9_pkg::*;
#(
   parameter int DEPTH = 4096,
   parameter int AW    = 12
) (
   input  logic             clk,
   input  logic             en,
   input  logic [NLANE-1:0] we,
   input  logic [AW-1:0]    adr,
   input  logic [DW-1:0]    din,
   output logic [DW-1:0]    dout
);

   logic [DW-1:0] mem_r [DEPTH];

   // Storage array: lane-masked write or registered word read.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int k = 0; k < NLANE; k++) begin
            if (we[k]) begin
               mem_r[adr][8*k +: 8] <= din[8*k +: 8];
            end
         end
         if (we == {NLANE{1'b0}}) begin
            dout <= mem_r[adr];
         end
      end
   end

endmodule

// File: rtl/cirno9_ram4ls_resp.sv
// -----------------------------------------------------------------------------
// cirno9_ram4ls_resp
//   Memory-side responder for the core load/store port. Accepts one request
//   at a time in IDLE, spends WAIT_CYC wait states, accesses the local SRAM
//   bank for one cycle and then pulses o_hs_ram4ls_rdy for one cycle.
//   Out-of-window addresses and simultaneous read+write report o_err and
//   leave the bank untouched, with the same latency as a normal access.
// Ports
//   clk              in   1    clock, rising edge
//   rst_n            in   1    asynchronous active-low reset
//   i_sram_ren       in   1    read request
//   i_sram_wen       in   4    byte-lane write enables
//   i_adr            in   32   byte address (bits [1:0] ignored)
//   i_wdat           in   32   write data
//   o_sram_rdat      out  32   read data, non-zero only in the rdy cycle of a read
//   o_hs_ram4ls_rdy  out  1    one-cycle completion strobe
//   o_err            out  1    error flag, valid with rdy
//   o_busy           out  1    high from the cycle after accept through rdy
// -----------------------------------------------------------------------------
module cirno9_ram4ls_resp
   import cirno9_pkg::*;
#(
   parameter int          DEPTH     = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          WAIT_CYC  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_sram_ren,
   input  logic [NLANE-1:0] i_sram_wen,
   input  logic [31:0]      i_adr,
   input  logic [DW-1:0]    i_wdat,
   output logic [DW-1:0]    o_sram_rdat,
   output logic             o_hs_ram4ls_rdy,
   output logic             o_err,
   output logic             o_busy
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + (33'(DEPTH) * 33'd4);

   state_t              state_r;
   state_t              state_nxt_s;
   logic [CW-1:0]       cnt_r;
   logic [AW-1:0]       idx_r;
   logic [DW-1:0]       wdat_r;
   logic [NLANE-1:0]    wen_r;
   logic                err_r;
   logic                rdy_r;
   logic                err_out_r;
   logic                rdat_en_r;
   logic                busy_r;
   logic                req_s;
   logic                accept_s;
   logic                bank_en_s;
   logic [DW-1:0]       bank_dout_s;

   assign req_s     = i_sram_ren | (|i_sram_wen);
   assign accept_s  = (state_r == ST_IDLE) && req_s;
   // Errored requests walk through ACC without touching the bank.
   assign bank_en_s = (state_r == ST_ACC) && !err_r;

   // Next-state logic of the access sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_s) begin
               state_nxt_s = (WAIT_CYC > 0) ? ST_WAIT : ST_ACC;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // <= 1 rather than == 1 so a zero count can never stall here.
            if (cnt_r <= 4'd1) begin
               state_nxt_s = ST_ACC;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_ACC:  state_nxt_s = ST_RESP;
         ST_RESP: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, request capture, wait counter and registered response flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 4'd0;
         idx_r     <= {AW{1'b0}};
         wdat_r    <= 32'h0000_0000;
         wen_r     <= 4'h0;
         err_r     <= 1'b0;
         rdy_r     <= 1'b0;
         err_out_r <= 1'b0;
         rdat_en_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            // Index is only meaningful when the window check passes.
            idx_r  <= AW'((i_adr - BASE_ADDR) >> 2'd2);
            wdat_r <= i_wdat;
            wen_r  <= i_sram_wen;
            err_r  <= !in_window(i_adr, BASE_ADDR, WIN_END) ||
                      (i_sram_ren && (|i_sram_wen));
            cnt_r  <= CW'(WAIT_CYC);
         end else if (state_r == ST_WAIT) begin
            cnt_r  <= cnt_r - 4'd1;
         end
         // Response flags are set on entry to RESP so they are pure flops.
         rdy_r     <= (state_nxt_s == ST_RESP);
         err_out_r <= (state_nxt_s == ST_RESP) && err_r;
         rdat_en_r <= (state_nxt_s == ST_RESP) && !err_r && (wen_r == 4'h0);
         busy_r    <= (state_nxt_s != ST_IDLE);
      end
   end

   cirno9_sram_bank #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_bank (
      .clk  (clk),
      .en   (bank_en_s),
      .we   (wen_r),
      .adr  (idx_r),
      .din  (wdat_r),
      .dout (bank_dout_s)
   );

   // Bank dout is itself a register; gate it so rdat is zero outside a read response.
   assign o_sram_rdat     = rdat_en_r ? bank_dout_s : 32'h0000_0000;
   assign o_hs_ram4ls_rdy = rdy_r;
   assign o_err           = err_out_r;
   assign o_busy          = busy_r;

endmodule

// File: tb/tb_cirno9_ram4ls_resp.sv
// -----------------------------------------------------------------------------
// tb_cirno9_ram4ls_resp
//   Three responder instances share one clock:
//     0: DEPTH 4096, BASE 0x0000, WAIT_CYC 0
//     1: DEPTH 16,   BASE 0x1000, WAIT_CYC 3
//     2: DEPTH 64,   BASE 0x0000, WAIT_CYC 4
//   Expected data/error values come from a word-addressed associative-array
//   memory model; expected latency is WAIT_CYC+2 for every access.
// -----------------------------------------------------------------------------
module tb_cirno9_ram4ls_resp;

   logic        clk;
   logic        rst_n  [3];
   logic        ren_t  [3];
   logic [3:0]  wen_t  [3];
   logic [31:0] adr_t  [3];
   logic [31:0] wdat_t [3];
   logic [31:0] rdat_t [3];
   logic        rdy_t  [3];
   logic        err_t  [3];
   logic        busy_t [3];

   int n_chk = 0;
   int n_err = 0;

   longint      base_m  [3] = '{64'h0, 64'h1000, 64'h0};
   longint      depth_m [3] = '{4096, 16, 64};
   int          lat_m   [3] = '{2, 5, 6};
   logic [31:0] mem_m [int];

   cirno9_ram4ls_resp #(.DEPTH(4096), .BASE_ADDR(32'h0000_0000), .WAIT_CYC(0)) u_a (
      .clk(clk), .rst_n(rst_n[0]), .i_sram_ren(ren_t[0]), .i_sram_wen(wen_t[0]),
      .i_adr(adr_t[0]), .i_wdat(wdat_t[0]), .o_sram_rdat(rdat_t[0]),
      .o_hs_ram4ls_rdy(rdy_t[0]), .o_err(err_t[0]), .o_busy(busy_t[0]));

   cirno9_ram4ls_resp #(.DEPTH(16), .BASE_ADDR(32'h0000_1000), .WAIT_CYC(3)) u_b (
      .clk(clk), .rst_n(rst_n[1]), .i_sram_ren(ren_t[1]), .i_sram_wen(wen_t[1]),
      .i_adr(adr_t[1]), .i_wdat(wdat_t[1]), .o_sram_rdat(rdat_t[1]),
      .o_hs_ram4ls_rdy(rdy_t[1]), .o_err(err_t[1]), .o_busy(busy_t[1]));

   cirno9_ram4ls_resp #(.DEPTH(64), .BASE_ADDR(32'h0000_0000), .WAIT_CYC(4)) u_c (
      .clk(clk), .rst_n(rst_n[2]), .i_sram_ren(ren_t[2]), .i_sram_wen(wen_t[2]),
      .i_adr(adr_t[2]), .i_wdat(wdat_t[2]), .o_sram_rdat(rdat_t[2]),
      .o_hs_ram4ls_rdy(rdy_t[2]), .o_err(err_t[2]), .o_busy(busy_t[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: window check, conflict check, lane-merged word store.
   task automatic model(input int k, input logic r, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] xr, output logic xe);
      longint      aa;
      int          key;
      logic [31:0] word;
      aa = longint'(a);
      xr = 32'h0;
      xe = (aa < base_m[k]) || (aa >= base_m[k] + 4 * depth_m[k]) || (r && (w != 4'h0));
      if (!xe) begin
         key  = k * 65536 + int'((aa - base_m[k]) / 4);
         word = mem_m.exists(key) ? mem_m[key] : 32'h0;
         if (w != 4'h0) begin
            for (int i = 0; i < 4; i++)
               if (w[i]) word[8*i +: 8] = d[8*i +: 8];
            mem_m[key] = word;
         end else begin
            xr = word;
         end
      end
   endtask

   // Drive one request from a falling edge, hold it until rdy, then drop it
   // and observe one idle cycle. Reports measured latency and trace flags.
   task automatic run_access(input int k, input logic r, input logic [3:0] w,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rd, output logic e, output int lat,
                             output bit busy_ok, output bit quiet_ok);
      ren_t[k] = r; wen_t[k] = w; adr_t[k] = a; wdat_t[k] = d;
      lat = -1; rd = 32'h0; e = 1'b0; busy_ok = 1'b1; quiet_ok = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (busy_t[k] !== 1'b1) busy_ok = 1'b0;
         if (rdy_t[k] === 1'b1) begin
            lat = c; rd = rdat_t[k]; e = err_t[k];
            break;
         end else if (err_t[k] !== 1'b0 || rdat_t[k] !== 32'h0) begin
            quiet_ok = 1'b0;
         end
      end
      ren_t[k] = 1'b0; wen_t[k] = 4'h0;
      @(negedge clk);
      if (rdy_t[k] !== 1'b0 || busy_t[k] !== 1'b0 || err_t[k] !== 1'b0 || rdat_t[k] !== 32'h0)
         quiet_ok = 1'b0;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         rst_n[k] = 1'b0; ren_t[k] = 1'b0; wen_t[k] = 4'h0; adr_t[k] = 32'h0; wdat_t[k] = 32'h0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if ({rdy_t[k], err_t[k], busy_t[k], rdat_t[k]} !== 35'h0) begin
            n_err++;
            $display("FAIL reset_out[%0d]: got rdy=%b err=%b busy=%b rdat=%h expected all 0",
                     k, rdy_t[k], err_t[k], busy_t[k], rdat_t[k]);
         end
         rst_n[k] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [31:0] rd, xr; logic e, xe; int lat; bit bok, qok;
      model(0, 1'b0, 4'hF, 32'h10, 32'hDEADBEEF, xr, xe);
      run_access(0, 1'b0, 4'hF, 32'h10, 32'hDEADBEEF, rd, e, lat, bok, qok);
      n_chk++;
      if (lat !== 2 || e !== xe || rd !== 32'h0) begin
         n_err++; $display("FAIL t1_write: got lat=%0d err=%b rdat=%h expected lat=2 err=0 rdat=0", lat, e, rd);
      end
      model(0, 1'b1, 4'h0, 32'h10, 32'h0, xr, xe);
      run_access(0, 1'b1, 4'h0, 32'h10, 32'h0, rd, e, lat, bok, qok);
      n_chk++;
      if (lat !== 2 || e !== 1'b0 || rd !== 32'hDEADBEEF || rd !== xr) begin
         n_err++; $display("FAIL t1_read: got lat=%0d err=%b rdat=%h expected lat=2 err=0 rdat=deadbeef", lat, e, rd);
      end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd, xr; logic e, xe; int lat; bit bok, qok;
      model(0, 1'b0, 4'b0100, 32'h10, 32'h00AA0000, xr, xe);
      run_access(0, 1'b0, 4'b0100, 32'h10, 32'h00AA0000, rd, e, lat, bok, qok);
      model(0, 1'b1, 4'h0, 32'h13, 32'h0, xr, xe);
      run_access(0, 1'b1, 4'h0, 32'h13, 32'h0, rd, e, lat, bok, qok);
      n_chk++;
      if (rd !== 32'hDEAABEEF || rd !== xr || e !== 1'b0) begin
         n_err++; $display("FAIL t2_lane_merge: got rdat=%h err=%b expected rdat=deaabeef err=0", rd, e);
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] rd, xr; logic e, xe; int lat; bit bok, qok;
      model(1, 1'b0, 4'hF, 32'h1004, 32'h5A5A_1234, xr, xe);
      run_access(1, 1'b0, 4'hF, 32'h1004, 32'h5A5A_1234, rd, e, lat, bok, qok);
      model(1, 1'b1, 4'h0, 32'h1004, 32'h0, xr, xe);
      run_access(1, 1'b1, 4'h0, 32'h1004, 32'h0, rd, e, lat, bok, qok);
      n_chk++;
      if (lat !== 5) begin n_err++; $display("FAIL t3_latency: got %0d expected 5", lat); end
      n_chk++;
      if (bok !== 1'b1) begin n_err++; $display("FAIL t3_busy: got busy_ok=%b expected 1", bok); end
      n_chk++;
      if (qok !== 1'b1) begin n_err++; $display("FAIL t3_quiet: got quiet_ok=%b expected 1", qok); end
      n_chk++;
      if (rd !== xr) begin n_err++; $display("FAIL t3_rdat: got %h expected %h", rd, xr); end
   endtask

   task automatic test_errors();
      logic [31:0] rd, xr; logic e, xe; int lat; bit bok, qok;
      logic [31:0] adrs [5] = '{32'h1040, 32'h0FFC, 32'h1000, 32'h1000, 32'h103C};
      logic        rens [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [3:0]  wens [5] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
      logic        errs [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      model(1, 1'b0, 4'hF, 32'h1000, 32'h1122_3344, xr, xe);
      run_access(1, 1'b0, 4'hF, 32'h1000, 32'h1122_3344, rd, e, lat, bok, qok);
      model(1, 1'b0, 4'hF, 32'h103C, 32'h7777_0000, xr, xe);
      run_access(1, 1'b0, 4'hF, 32'h103C, 32'h7777_0000, rd, e, lat, bok, qok);
      for (int i = 0; i < 5; i++) begin
         model(1, rens[i], wens[i], adrs[i], 32'hFFFF_FFFF, xr, xe);
         run_access(1, rens[i], wens[i], adrs[i], 32'hFFFF_FFFF, rd, e, lat, bok, qok);
         n_chk++;
         if (e !== errs[i] || e !== xe || rd !== xr || lat !== 5) begin
            n_err++;
            $display("FAIL t4_err[%0d]: got err=%b rdat=%h lat=%0d expected err=%b rdat=%h lat=5",
                     i, e, rd, lat, errs[i], xr);
         end
      end
      n_chk++;
      if (rd !== 32'h7777_0000) begin n_err++; $display("FAIL t4_last_word: got %h expected 77770000", rd); end
      model(0, 1'b1, 4'h0, 32'hFFFF_FFFC, 32'h0, xr, xe);
      run_access(0, 1'b1, 4'h0, 32'hFFFF_FFFC, 32'h0, rd, e, lat, bok, qok);
      n_chk++;
      if (e !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
         n_err++; $display("FAIL t4_top_addr: got err=%b rdat=%h lat=%0d expected err=1 rdat=0 lat=2", e, rd, lat);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, xr; logic e, xe; int lat; bit bok, qok; bit saw;
      model(2, 1'b0, 4'hF, 32'h20, 32'hCAFE_F00D, xr, xe);
      run_access(2, 1'b0, 4'hF, 32'h20, 32'hCAFE_F00D, rd, e, lat, bok, qok);
      n_chk++;
      if (lat !== 6) begin n_err++; $display("FAIL t5_latency: got %0d expected 6", lat); end
      ren_t[2] = 1'b0; wen_t[2] = 4'hF; adr_t[2] = 32'h20; wdat_t[2] = 32'h0BAD_BEEF;
      repeat (2) @(negedge clk);
      n_chk++;
      if (busy_t[2] !== 1'b1 || rdy_t[2] !== 1'b0) begin
         n_err++; $display("FAIL t5_in_wait: got busy=%b rdy=%b expected busy=1 rdy=0", busy_t[2], rdy_t[2]);
      end
      #2 rst_n[2] = 1'b0;
      #1;
      n_chk++;
      if ({rdy_t[2], err_t[2], busy_t[2], rdat_t[2]} !== 35'h0) begin
         n_err++; $display("FAIL t5_async_clear: got rdy=%b err=%b busy=%b rdat=%h expected all 0",
                           rdy_t[2], err_t[2], busy_t[2], rdat_t[2]);
      end
      wen_t[2] = 4'h0;
      saw = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (rdy_t[2] !== 1'b0 || busy_t[2] !== 1'b0) saw = 1'b1;
      end
      rst_n[2] = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (rdy_t[2] !== 1'b0) saw = 1'b1;
      end
      n_chk++;
      if (saw !== 1'b0) begin n_err++; $display("FAIL t5_no_rdy: got stray rdy/busy=%b expected 0", saw); end
      model(2, 1'b1, 4'h0, 32'h20, 32'h0, xr, xe);
      run_access(2, 1'b1, 4'h0, 32'h20, 32'h0, rd, e, lat, bok, qok);
      n_chk++;
      if (rd !== 32'hCAFE_F00D || rd !== xr || e !== 1'b0) begin
         n_err++; $display("FAIL t5_old_data: got rdat=%h err=%b expected cafef00d err=0", rd, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, xr, d; logic e, xe; int lat; bit bok, qok;
      logic [7:0] rtr, btr;
      d = $urandom;
      model(0, 1'b0, 4'hF, 32'h40, d, xr, xe);
      ren_t[0] = 1'b0; wen_t[0] = 4'hF; adr_t[0] = 32'h40; wdat_t[0] = d;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         rtr[c] = rdy_t[0];
         btr[c] = busy_t[0];
         // Held through the whole cycle after rdy, then released.
         if (c == 3) wen_t[0] = 4'h0;
      end
      n_chk++;
      if (rtr !== 8'b0001_0010) begin n_err++; $display("FAIL t6_rdy_trace: got %b expected 00010010", rtr); end
      n_chk++;
      if (btr !== 8'b0001_1011) begin n_err++; $display("FAIL t6_busy_trace: got %b expected 00011011", btr); end
      model(0, 1'b1, 4'h0, 32'h40, 32'h0, xr, xe);
      run_access(0, 1'b1, 4'h0, 32'h40, 32'h0, rd, e, lat, bok, qok);
      n_chk++;
      if (rd !== xr) begin n_err++; $display("FAIL t6_data: got %h expected %h", rd, xr); end
   endtask

   task automatic test_random();
      logic [31:0] rd, xr, a, d; logic e, xe, r; logic [3:0] w; int lat, sel; bit bok, qok;
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         model(1, 1'b0, 4'hF, 32'h1000 + 32'(4 * i), d, xr, xe);
         run_access(1, 1'b0, 4'hF, 32'h1000 + 32'(4 * i), d, rd, e, lat, bok, qok);
      end
      for (int i = 0; i < 40; i++) begin
         a   = 32'h0FF0 + 32'(4 * $urandom_range(0, 23)) + 32'($urandom_range(0, 3));
         d   = $urandom;
         sel = $urandom_range(0, 9);
         r   = (sel < 5) || (sel == 9);
         w   = (sel < 5) ? 4'h0 : 4'($urandom_range(1, 15));
         model(1, r, w, a, d, xr, xe);
         run_access(1, r, w, a, d, rd, e, lat, bok, qok);
         n_chk++;
         if (rd !== xr || e !== xe || lat !== lat_m[1] || bok !== 1'b1 || qok !== 1'b1) begin
            n_err++;
            $display("FAIL rand[%0d] a=%h r=%b w=%h: got rdat=%h err=%b lat=%0d busy_ok=%b quiet_ok=%b expected rdat=%h err=%b lat=%0d busy_ok=1 quiet_ok=1",
                     i, a, r, w, rd, e, lat, bok, qok, xr, xe, lat_m[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_byte_lanes();
      test_wait_states();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
